mul8_seq_ctrl: RTL and testbench
================================

Name: mul8_seq_ctrl

Overview:
Sequential shift-add 8x8 multiplier with its control FSM, used as the core of the tt_um_8x8mul top.
- Accepts an operand pair on a start strobe and computes the unsigned product one multiplier bit per clock.
- Signals completion and holds the 2*WIDTH-bit result.
- Presents the result one byte at a time for the 8-bit uo_out pins.

Parameters:
WIDTH, 8, operand width in bits; product is 2*WIDTH bits.

Ports:
clk  in  1  system clock; all state on rising edge
rst_n  in  1  reset; synchronous, active-low
ena  in  1  design enable; 0 freezes all state and ignores start
start  in  1  request; sampled each edge
op_a  in  WIDTH  multiplicand, unsigned; sampled on accepted start
op_b  in  WIDTH  multiplier, unsigned; sampled on accepted start
out_sel  in  1  0 = low byte of product on byte_out, 1 = high byte
busy  out  1  high while in RUN
done  out  1  single-cycle completion pulse (high in DONE state)
valid  out  1  product holds a completed result
product  out  2*WIDTH  last completed product
byte_out  out  WIDTH  combinational mux of product by out_sel

Behaviour:
- Reset: rst_n=0 at an edge sets the following, regardless of state or ena:
  - state=IDLE, busy=0, done=0, valid=0, product=0
  - internal accumulator, operand registers and bit counter cleared
- ena=0: no register changes except reset; start ignored; outputs hold their current values.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 accepts the request. Latch mcand=op_a, mplr=op_b; clear acc and cnt; clear valid; go to RUN.
  - RUN: each edge:
    - if mplr[0], upper half {carry,acc} = acc + mcand (WIDTH+1-bit sum)
    - shift {carry,acc,mplr} right by one
    - cnt++
  - RUN exit: on the edge where cnt==WIDTH-1, write the final {acc,mplr} into product, set valid=1, go to DONE.
  - DONE: done=1 for exactly this cycle.
    - start=1: accept a new request exactly as in IDLE (back-to-back) and go to RUN.
    - otherwise go to IDLE.
- start in RUN is ignored; operands are not resampled.
- Latency: start accepted at edge 0 → RUN over edges 1..WIDTH → done high in the cycle after edge WIDTH. Start-to-done is WIDTH+1 clocks (9 at default). Throughput is one product per WIDTH+1 clocks when back-to-back.
- valid/product: hold until the next accepted start. valid drops on the accept edge; product keeps its old value until the new result is written.
- Arithmetic: unsigned only; the full 2*WIDTH-bit result is kept with no truncation (255*255=0xFE01).
- byte_out = out_sel ? product[2W-1:W] : product[W-1:0]. Purely combinational, valid in any state.
- Reset mid-RUN: aborts; no done pulse; product=0, valid=0.
- Simultaneous reset and start: reset wins.

Decomposition:
- Package mul8_pkg holds:
  - state typedef {IDLE, RUN, DONE}
  - default WIDTH constant
  - CNT_W = $clog2(WIDTH)
- Sub-module mul8_shift_add_dp holds the datapath: mcand/acc/mplr registers, WIDTH+1-bit adder, shifter.
  - Controlled by load/step strobes from the FSM in mul8_seq_ctrl.
  - Exposes the {acc,mplr} result.
- The FSM, counter, product/valid registers and output mux stay in mul8_seq_ctrl.

Test Plan:
1. Reset: hold rst_n=0 for 2 clocks with start=1, op_a=0xFF → busy=0, done=0, valid=0, product=0x0000, byte_out=0x00.
2. Basic: start one cycle with op_a=13, op_b=11 → busy for 8 clocks, done pulse on clock 9, product=0x008F. byte_out=0x8F at out_sel=0 and 0x00 at out_sel=1.
3. Corners: 255*255 → 0xFE01; 0*200 → 0x0000; 1*255 → 0x00FF; 128*2 → 0x0100. Each with done exactly 9 clocks after start.
4. Busy start: start 6*7, then at RUN clock 3 pulse start with op_a=op_b=0xFF → ignored; product=42, single done pulse.
5. Reset mid-op: start 200*3, drop rst_n at RUN clock 4 → IDLE, no done, valid=0. Then start 7*9 → product=63 after 9 clocks.
6. ena/back-to-back: ena=0 for 3 clocks mid-RUN → done delayed by exactly 3 clocks, result correct. Start 5*5 asserted in the DONE cycle → next done 9 clocks later, product=25.

Source files
------------

// File: rtl/mul8_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mul8_pkg;

    localparam int MUL8_WIDTH = 8;
    localparam int CNT_W      = $clog2(MUL8_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul8_shift_add_dp.sv
// Shift-add datapath: multiplicand, accumulator and multiplier/low-product registers.
module mul8_shift_add_dp
    import mul8_pkg::*;
#(
    parameter int WIDTH = MUL8_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic               i_step,
    input  logic [WIDTH-1:0]   i_op_a,
    input  logic [WIDTH-1:0]   i_op_b,
    output logic [2*WIDTH-1:0] o_next
);

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mplr;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_acc_nx;
    logic [WIDTH-1:0] w_mplr_nx;

    // The carry-out of the add becomes the new accumulator MSB after the shift.
    always_comb begin
        w_sum     = {1'b0, r_acc} + (r_mplr[0] ? {1'b0, r_mcand} : '0);
        w_acc_nx  = w_sum[WIDTH:1];
        w_mplr_nx = {w_sum[0], r_mplr[WIDTH-1:1]};
    end

    assign o_next = {w_acc_nx, w_mplr_nx};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mcand <= '0;
            r_acc   <= '0;
            r_mplr  <= '0;
        end else if (i_load) begin
            r_mcand <= i_op_a;
            r_mplr  <= i_op_b;
            r_acc   <= '0;
        end else if (i_step) begin
            r_acc   <= w_acc_nx;
            r_mplr  <= w_mplr_nx;
        end
    end

endmodule

// File: rtl/mul8_seq_ctrl.sv
// Control FSM, bit counter and result registers around the shift-add datapath.
module mul8_seq_ctrl
    import mul8_pkg::*;
#(
    parameter int WIDTH = MUL8_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               start,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    input  logic               out_sel,
    output logic               busy,
    output logic               done,
    output logic               valid,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   byte_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t               r_state;
    state_t               w_state_nx;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_product;
    logic                 r_valid;
    logic                 w_load;
    logic                 w_step;
    logic                 w_finish;
    logic [2*WIDTH-1:0]   w_dp_next;

    mul8_shift_add_dp #(.WIDTH(WIDTH)) u_dp (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_step (w_step),
        .i_op_a (op_a),
        .i_op_b (op_b),
        .o_next (w_dp_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else if (ena) begin
            r_state <= w_state_nx;
        end
    end

    // All strobes are gated by ena so a disabled cycle changes nothing.
    always_comb begin
        w_state_nx = r_state;
        w_load     = 1'b0;
        w_step     = 1'b0;
        w_finish   = 1'b0;
        if (ena) begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        w_load     = 1'b1;
                        w_state_nx = RUN;
                    end
                end
                RUN: begin
                    w_step = 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        w_finish   = 1'b1;
                        w_state_nx = DONE;
                    end
                end
                DONE: begin
                    if (start) begin
                        w_load     = 1'b1;
                        w_state_nx = RUN;
                    end else begin
                        w_state_nx = IDLE;
                    end
                end
                default: w_state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_product <= '0;
            r_valid   <= 1'b0;
        end else begin
            if (w_load) begin
                r_cnt   <= '0;
                r_valid <= 1'b0;
            end else if (w_step) begin
                r_cnt   <= r_cnt + 1'b1;
            end
            if (w_finish) begin
                r_product <= w_dp_next;
                r_valid   <= 1'b1;
            end
        end
    end

    assign busy     = (r_state == RUN);
    assign done     = (r_state == DONE);
    assign valid    = r_valid;
    assign product  = r_product;
    assign byte_out = out_sel ? r_product[2*WIDTH-1:WIDTH] : r_product[WIDTH-1:0];

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// Self-checking bench for mul8_seq_ctrl against an arithmetic reference model.
module tb_mul8_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        start;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic        out_sel;
    logic        busy;
    logic        done;
    logic        valid;
    logic [15:0] product;
    logic [7:0]  byte_out;

    int n_tests = 0;
    int n_fail  = 0;

    localparam int LAT = 9;

    mul8_seq_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .out_sel  (out_sel),
        .busy     (busy),
        .done     (done),
        .valid    (valid),
        .product  (product),
        .byte_out (byte_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request and waits (bounded) for done; lat counts clocks from the accept edge.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, output int lat,
                          output int busy_bad, output logic v_acc, output logic [15:0] p_acc);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        v_acc    = valid;
        p_acc    = product;
        lat      = 1;
        busy_bad = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy !== 1'b1) busy_bad++;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; start = 1'b1; op_a = 8'hFF; op_b = 8'hFF; out_sel = 1'b0;
        tick();
        tick();
        n_tests++;
        if ({busy, done, valid} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got busy/done/valid=%b want 000", {busy, done, valid});
        end
        n_tests++;
        if (product !== 16'h0000 || byte_out !== 8'h00) begin
            n_fail++; $display("FAIL reset_product: got %h/%h want 0000/00", product, byte_out);
        end
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_release_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_basic();
        int lat, bb; logic v; logic [15:0] p;
        run_op(8'd13, 8'd11, lat, bb, v, p);
        n_tests++;
        if (lat !== LAT || bb !== 0) begin
            n_fail++; $display("FAIL basic_timing: latency=%0d busy_gaps=%0d want %0d/0", lat, bb, LAT);
        end
        n_tests++;
        if (product !== 16'h008F || valid !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_result: product=%h valid=%b busy=%b want 008F 1 0", product, valid, busy);
        end
        out_sel = 1'b0; #1;
        n_tests++;
        if (byte_out !== 8'h8F) begin
            n_fail++; $display("FAIL basic_byte_lo: got %h want 8f", byte_out);
        end
        out_sel = 1'b1; #1;
        n_tests++;
        if (byte_out !== 8'h00) begin
            n_fail++; $display("FAIL basic_byte_hi: got %h want 00", byte_out);
        end
        out_sel = 1'b0;
        tick();
        n_tests++;
        if (done !== 1'b0 || valid !== 1'b1 || product !== 16'h008F) begin
            n_fail++; $display("FAIL basic_hold: done=%b valid=%b product=%h want 0 1 008f", done, valid, product);
        end
    endtask

    task automatic test_corners();
        logic [7:0] ca [12];
        logic [7:0] cb [12];
        logic [15:0] prev;
        int lat, bb; logic v; logic [15:0] p;
        ca[0] = 8'd255; cb[0] = 8'd255;
        ca[1] = 8'd0;   cb[1] = 8'd200;
        ca[2] = 8'd1;   cb[2] = 8'd255;
        ca[3] = 8'd128; cb[3] = 8'd2;
        for (int i = 4; i < 12; i++) begin
            ca[i] = 8'($urandom_range(0, 255));
            cb[i] = 8'($urandom_range(0, 255));
        end
        prev = 16'h008F;
        for (int i = 0; i < 12; i++) begin
            logic [15:0] exp_p;
            exp_p = 16'(ca[i]) * 16'(cb[i]);
            run_op(ca[i], cb[i], lat, bb, v, p);
            n_tests++;
            if (v !== 1'b0 || p !== prev) begin
                n_fail++; $display("FAIL corner_accept[%0d]: valid=%b product=%h want 0 %h", i, v, p, prev);
            end
            n_tests++;
            if (lat !== LAT || bb !== 0) begin
                n_fail++; $display("FAIL corner_timing[%0d]: latency=%0d busy_gaps=%0d want %0d/0", i, lat, bb, LAT);
            end
            n_tests++;
            if (product !== exp_p || valid !== 1'b1) begin
                n_fail++; $display("FAIL corner_result[%0d] %0d*%0d: got %h valid=%b want %h", i, ca[i], cb[i], product, valid, exp_p);
            end
            out_sel = 1'b1; #1;
            n_tests++;
            if (byte_out !== exp_p[15:8]) begin
                n_fail++; $display("FAIL corner_byte_hi[%0d]: got %h want %h", i, byte_out, exp_p[15:8]);
            end
            out_sel = 1'b0;
            prev = exp_p;
            tick();
        end
    endtask

    task automatic test_busy_start();
        int ndone, first;
        op_a = 8'd6; op_b = 8'd7; start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0; first = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (done === 1'b1) begin
                ndone++;
                if (first == 0) first = cyc;
            end
            start = (cyc == 3);
            op_a  = (cyc == 3) ? 8'hFF : 8'd6;
            op_b  = (cyc == 3) ? 8'hFF : 8'd7;
            tick();
        end
        start = 1'b0;
        n_tests++;
        if (ndone !== 1 || first !== LAT) begin
            n_fail++; $display("FAIL busy_start_done: pulses=%0d first=%0d want 1/%0d", ndone, first, LAT);
        end
        n_tests++;
        if (product !== 16'd42 || valid !== 1'b1) begin
            n_fail++; $display("FAIL busy_start_result: got %0d valid=%b want 42 1", product, valid);
        end
    endtask

    task automatic test_reset_mid();
        int ndone, lat, bb; logic v; logic [15:0] p;
        op_a = 8'd200; op_b = 8'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        start = 1'b1;
        tick();
        rst_n = 1'b1;
        start = 1'b0;
        n_tests++;
        if ({busy, done, valid} !== 3'b000 || product !== 16'h0000) begin
            n_fail++; $display("FAIL reset_mid_state: bdv=%b product=%h want 000 0000", {busy, done, valid}, product);
        end
        ndone = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (done === 1'b1 || busy === 1'b1) ndone++;
            tick();
        end
        n_tests++;
        if (ndone !== 0) begin
            n_fail++; $display("FAIL reset_mid_quiet: activity cycles=%0d want 0", ndone);
        end
        run_op(8'd7, 8'd9, lat, bb, v, p);
        n_tests++;
        if (lat !== LAT || product !== 16'd63 || valid !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_recover: latency=%0d product=%0d want %0d 63", lat, product, LAT);
        end
        tick();
    endtask

    task automatic test_ena_back_to_back();
        logic [7:0] a, b;
        int lat, bb; logic v; logic [15:0] p;
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        op_a = a; op_b = b; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        repeat (2) begin tick(); lat++; end
        ena = 1'b0;
        repeat (3) begin tick(); lat++; end
        n_tests++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL ena_freeze: busy=%b done=%b want 1 0", busy, done);
        end
        ena = 1'b1;
        while (done !== 1'b1 && lat < 40) begin tick(); lat++; end
        n_tests++;
        if (lat !== LAT + 3 || product !== 16'(a) * 16'(b)) begin
            n_fail++; $display("FAIL ena_delay: latency=%0d product=%h want %0d %h", lat, product, LAT + 3, 16'(a) * 16'(b));
        end
        run_op(8'd5, 8'd5, lat, bb, v, p);
        n_tests++;
        if (v !== 1'b0 || lat !== LAT || bb !== 0) begin
            n_fail++; $display("FAIL b2b_timing: valid_at_accept=%b latency=%0d gaps=%0d want 0 %0d 0", v, lat, bb, LAT);
        end
        n_tests++;
        if (product !== 16'd25) begin
            n_fail++; $display("FAIL b2b_result: got %0d want 25", product);
        end
        tick();
        ena = 1'b0; start = 1'b1; op_a = 8'd3; op_b = 8'd3;
        repeat (2) tick();
        n_tests++;
        if (busy !== 1'b0 || valid !== 1'b1 || product !== 16'd25) begin
            n_fail++; $display("FAIL ena_ignore_start: busy=%b valid=%b product=%0d want 0 1 25", busy, valid, product);
        end
        start = 1'b0; ena = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_busy_start();
        test_reset_mid();
        test_ena_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
